// File: rtl/shacc_array_if.sv
// Beat/result handshake bundle for shacc_array: input beats on i_*, tile results on o_*.
interface shacc_array_if #(
    parameter int N = 8,
    parameter int W = 32,
    parameter int A = 16
);
    logic           i_valid;
    logic           i_ready;
    logic [N*A-1:0] i_data;
    logic           o_valid;
    logic           o_ready;
    logic [N*W-1:0] o_data;
    logic [N-1:0]   o_ovf;

    modport slave  (input  i_valid, i_data, o_ready, output i_ready, o_valid, o_data, o_ovf);
    modport master (output i_valid, i_data, o_ready, input  i_ready, o_valid, o_data, o_ovf);
endinterface

// File: rtl/shacc_array.sv
// Multi-lane bit-plane-serial shifter-accumulator with plane sequencer.
// Define SHACC_ARRAY_SAT_EN for per-step saturation and sticky per-lane overflow flags.
module shacc_lane #(
    parameter int W = 32,
    parameter int A = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic                i_first,
    input  logic                i_neg,
    input  logic signed [A-1:0] i_in,
    output logic [W-1:0]        o_acc,
    output logic                o_ovf
);
`ifdef SHACC_ARRAY_SAT_EN
    localparam int SW = W + 2;
`else
    localparam int SW = W;
`endif

    logic signed [W-1:0]  r_acc;
    logic signed [SW-1:0] w_in, w_accx, w_sum;
    logic [W-1:0]         w_next;

    assign w_in   = SW'(i_in);
    assign w_accx = SW'(r_acc);

    always_comb begin
        w_sum = w_accx + w_accx + w_in;
        if (i_first) w_sum = i_neg ? -w_in : w_in;
    end

`ifdef SHACC_ARRAY_SAT_EN
    localparam logic signed [SW-1:0] MAXV = SW'({1'b0, {(W-1){1'b1}}});
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic w_hi, w_lo, r_ovf;
    assign w_hi   = w_sum > MAXV;
    assign w_lo   = w_sum < MINV;
    assign w_next = w_hi ? MAXV[W-1:0] : (w_lo ? MINV[W-1:0] : w_sum[W-1:0]);

    // Sticky within a tile; the first plane restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_ovf <= 1'b0;
        else if (i_clr) r_ovf <= 1'b0;
        else if (i_en)  r_ovf <= (w_hi | w_lo) | (r_ovf & ~i_first);
    end
    assign o_ovf = r_ovf;
`else
    assign w_next = w_sum;
    assign o_ovf  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_acc <= '0;
        else if (i_clr) r_acc <= '0;
        else if (i_en)  r_acc <= w_next;
    end
    assign o_acc = r_acc;
endmodule

module shacc_array #(
    parameter int N  = 8,
    parameter int W  = 32,
    parameter int A  = 16,
    parameter int PW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [PW-1:0] cfg_prec,
    input  logic          cfg_signed,
    shacc_array_if.slave  bus,
    output logic          busy
);
    typedef enum logic {S_ACC, S_HOLD} state_t;

    state_t              r_state, w_state_nx;
    logic [PW-1:0]       r_k, r_prec, w_prec;
    logic                w_accept, w_first, w_last;
    logic [N-1:0][W-1:0] w_acc;
    logic [N-1:0]        w_ovf;

    assign bus.i_ready = (r_state == S_ACC) & ~clr & ~rst;
    assign bus.o_valid = (r_state == S_HOLD);
    assign w_accept    = bus.i_valid & bus.i_ready;
    assign w_first     = (r_k == '0);
    // The first plane uses live config; later planes use the copy latched on it.
    assign w_prec      = w_first ? cfg_prec : r_prec;
    assign w_last      = (w_prec <= PW'(1)) || (r_k == w_prec - PW'(1));
    assign busy        = (r_k != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_ACC;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (clr)
            w_state_nx = S_ACC;
        else case (r_state)
            S_ACC:  if (w_accept && w_last) w_state_nx = S_HOLD;
            S_HOLD: if (bus.o_ready)        w_state_nx = S_ACC;
            default: w_state_nx = S_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k    <= '0;
            r_prec <= '0;
        end else if (clr) begin
            r_k    <= '0;
        end else if (w_accept) begin
            if (w_first) r_prec <= cfg_prec;
            r_k <= w_last ? '0 : r_k + PW'(1);
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        shacc_lane #(.W(W), .A(A)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_clr  (clr),
            .i_en   (w_accept),
            .i_first(w_first),
            .i_neg  (cfg_signed),
            .i_in   (bus.i_data[g*A +: A]),
            .o_acc  (w_acc[g]),
            .o_ovf  (w_ovf[g])
        );
    end

    assign bus.o_data = w_acc;
    assign bus.o_ovf  = w_ovf;
endmodule

// File: tb/tb_shacc_array.sv
// Scoreboard bench for shacc_array: a wide instance (N=2,W=32,A=8) and a narrow one (N=1,W=10,A=8).
module tb_shacc_array;
    logic       clk = 0, rst = 1, clr = 0, cfg_signed = 0;
    logic [4:0] cfg_prec = 5'd1;
    logic       busy_a, busy_s;
    int         total = 0, bad = 0;

    logic [63:0] qa[$];
    logic [10:0] qs[$];

    shacc_array_if #(.N(2), .W(32), .A(8)) ma ();
    shacc_array_if #(.N(1), .W(10), .A(8)) ms ();

    shacc_array #(.N(2), .W(32), .A(8), .PW(5)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .cfg_prec(cfg_prec), .cfg_signed(cfg_signed),
        .bus(ma.slave), .busy(busy_a)
    );
    shacc_array #(.N(1), .W(10), .A(8), .PW(5)) u_s (
        .clk(clk), .rst(rst), .clr(clr), .cfg_prec(cfg_prec), .cfg_signed(cfg_signed),
        .bus(ms.slave), .busy(busy_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ma.o_valid && ma.o_ready) begin
            if (qa.size() == 0) chk("a_unexpected_result", 1, 0);
            else chk("a_result", ma.o_data, qa.pop_front());
        end
        if (ms.o_valid && ms.o_ready) begin
            if (qs.size() == 0) chk("s_unexpected_result", 1, 0);
            else chk("s_result", {ms.o_ovf, ms.o_data}, qs.pop_front());
        end
    end

    task automatic beat_a(input logic [7:0] d0, input logic [7:0] d1);
        bit done = 0;
        ma.i_data  = {d1, d0};
        ma.i_valid = 1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk); done = ma.i_ready;
            @(posedge clk); #1;
        end
        ma.i_valid = 0;
        if (!done) chk("a_beat_timeout", 0, 1);
    endtask

    task automatic beat_s(input logic [7:0] d0);
        bit done = 0;
        ms.i_data  = d0;
        ms.i_valid = 1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk); done = ms.i_ready;
            @(posedge clk); #1;
        end
        ms.i_valid = 0;
        if (!done) chk("s_beat_timeout", 0, 1);
    endtask

    task automatic drain();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ma.i_valid = 0; ma.i_data = '0; ma.o_ready = 1;
        ms.i_valid = 0; ms.i_data = '0; ms.o_ready = 1;
        #3;
        chk("rst_i_ready", ma.i_ready, 0);
        chk("rst_o_valid", ma.o_valid, 0);
        chk("rst_o_data",  ma.o_data, 0);
        chk("rst_busy",    busy_a, 0);
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1;

        // T1: single-plane tile, one-cycle o_valid
        cfg_prec = 1; cfg_signed = 0;
        qa.push_back({32'hFFFFFFFD, 32'd5});
        beat_a(8'd5, 8'hFD);
        chk("t1_o_valid_hi", ma.o_valid, 1);
        chk("t1_i_ready_lo", ma.i_ready, 0);
        @(posedge clk); #1;
        chk("t1_o_valid_lo", ma.o_valid, 0);
        chk("t1_i_ready_hi", ma.i_ready, 1);

        // T2: three planes unsigned then signed
        cfg_prec = 3;
        qa.push_back({32'd3, 32'd5});
        beat_a(8'd1, 8'd0);
        chk("t2_busy_mid", busy_a, 1);
        beat_a(8'd0, 8'd1);
        beat_a(8'd1, 8'd1);
        cfg_signed = 1;
        qa.push_back({32'd3, 32'hFFFFFFFD});
        beat_a(8'd1, 8'd0);
        beat_a(8'd0, 8'd1);
        beat_a(8'd1, 8'd1);
        drain();

        // T3: backpressure in HOLD, i_valid ignored
        cfg_signed = 0; ma.o_ready = 0;
        qa.push_back({32'hFFFFFFF9, 32'd7});
        repeat (3) beat_a(8'd1, 8'hFF);
        ma.i_valid = 1; ma.i_data = {8'd9, 8'd9};
        repeat (4) begin
            @(posedge clk); #1;
            chk("t3_hold_i_ready", ma.i_ready, 0);
            chk("t3_hold_o_valid", ma.o_valid, 1);
            chk("t3_hold_o_data",  ma.o_data, {32'hFFFFFFF9, 32'd7});
        end
        ma.i_valid = 0; ma.o_ready = 1;
        @(posedge clk); #1;
        chk("t3_busy_after", busy_a, 0);
        chk("t3_i_ready_after", ma.i_ready, 1);
        qa.push_back({32'd1, 32'd11});
        beat_a(8'd1, 8'd0);
        beat_a(8'd2, 8'd0);
        beat_a(8'd3, 8'd1);
        drain();

        // T4: clr mid-tile with a beat presented
        cfg_prec = 4;
        beat_a(8'd3, 8'd3);
        beat_a(8'd3, 8'd3);
        clr = 1; ma.i_valid = 1; ma.i_data = {8'd7, 8'd7};
        @(negedge clk);
        chk("t4_clr_i_ready", ma.i_ready, 0);
        @(posedge clk); #1;
        clr = 0; ma.i_valid = 0;
        chk("t4_clr_busy", busy_a, 0);
        qa.push_back({32'd30, 32'd15});
        repeat (4) beat_a(8'd1, 8'd2);
        drain();

        // T5: asynchronous reset during HOLD
        cfg_prec = 2; ma.o_ready = 0;
        beat_a(8'd1, 8'd1);
        beat_a(8'd1, 8'd1);
        chk("t5_in_hold", ma.o_valid, 1);
        #2; rst = 1; #1;
        chk("t5_rst_o_valid", ma.o_valid, 0);
        chk("t5_rst_o_data",  ma.o_data, 0);
        chk("t5_rst_i_ready", ma.i_ready, 0);
        @(posedge clk); #3; rst = 0;
        @(posedge clk); #1;
        chk("t5_after_i_ready", ma.i_ready, 1);
        ma.o_ready = 1; cfg_prec = 1;
        qa.push_back({32'hFFFFFFFC, 32'd4});
        beat_a(8'd4, 8'hFC);
        drain();

        // T6: narrow accumulator overflow, then a clean tile
        cfg_prec = 4; cfg_signed = 0;
`ifdef SHACC_ARRAY_SAT_EN
        qs.push_back({1'b1, 10'd511});
`else
        qs.push_back({1'b0, 10'h371});
`endif
        repeat (4) beat_s(8'd127);
        cfg_prec = 1;
        qs.push_back({1'b0, 10'd1});
        beat_s(8'd1);
        drain();

        chk("a_queue_empty", qa.size(), 0);
        chk("s_queue_empty", qs.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
